charger_controller: RTL and testbench

Central FSM of the coin-operated mobile phone charger. Accepts coin/start/cancel/power pulses, accumulates the balance, converts it to charge time and counts it down on a 1 s tick.
- Drives the 3-bit state code consumed by the downstream state-to-LED displayer.
- Drives balance and remaining-time values for the numeric display path.

---
 rtl/charger_pkg.sv | 36 +++
 rtl/charger_if.sv | 26 ++
 rtl/charger_tick_gen.sv | 29 ++
 rtl/charger_controller.sv | 157 +++++++++++++++
 tb/tb_charger_controller.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/charger_pkg.sv
// Shared constants for the coin-operated charger: state codes decoded by the LED displayer,
// value widths and the saturating balance adder.
package charger_pkg;

    localparam int STATE_W = 3;
    localparam int MONEY_W = 5;
    localparam int TIME_W  = 6;

    // Codes must match the downstream state-to-LED decode exactly.
    typedef enum logic [STATE_W-1:0] {
        S_OFF     = 3'd0,
        S_STANDBY = 3'd1,
        S_INPUT   = 3'd2,
        S_CHARGE  = 3'd3,
        S_DONE    = 3'd4
    } state_e;

    function automatic logic [MONEY_W-1:0] coin_value(input logic coin_1, input logic coin_10);
        logic [MONEY_W-1:0] val;
        val = '0;
        if (coin_1)  val = val + MONEY_W'(1);
        if (coin_10) val = val + MONEY_W'(10);
        return val;
    endfunction

    // One extra bit of headroom so 31 + 11 style overflow is caught before clamping.
    function automatic logic [MONEY_W-1:0] sat_add(input logic [MONEY_W-1:0] a,
                                                  input logic [MONEY_W-1:0] b,
                                                  input int                 max_val);
        logic [MONEY_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum > (MONEY_W+1)'(max_val)) return MONEY_W'(max_val);
        return sum[MONEY_W-1:0];
    endfunction

endpackage

// File: rtl/charger_if.sv
// Pulse inputs from the front panel and status outputs towards the display path.
// The controller uses the slave modport; whoever drives the pulses uses master.
interface charger_if;
    import charger_pkg::*;

    logic               power_on;
    logic               power_off;
    logic               coin_1;
    logic               coin_10;
    logic               start;
    logic               cancel;
    logic [STATE_W-1:0] state;
    logic [MONEY_W-1:0] money;
    logic [TIME_W-1:0]  remain_time;

    modport master (
        output power_on, power_off, coin_1, coin_10, start, cancel,
        input  state, money, remain_time
    );

    modport slave (
        input  power_on, power_off, coin_1, coin_10, start, cancel,
        output state, money, remain_time
    );

endinterface

// File: rtl/charger_tick_gen.sv
// Prescaler producing a one-cycle tick every TICK_DIV clocks; a synchronous clear
// restarts the period so the next tick lands exactly TICK_DIV cycles after it.
module tick_gen #(
    parameter int TICK_DIV = 100000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);
    localparam int                CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || tick) cnt_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/charger_controller.sv
// Central FSM of the coin-operated phone charger: balance entry, charge countdown, state code.
// Define CHARGER_TIMEOUT_EN to abort idle coin entry after IDLE_TIMEOUT ticks.
module charger_controller
    import charger_pkg::*;
#(
    parameter int TICK_DIV     = 100000000,
    parameter int MAX_MONEY    = 20,
    parameter int SEC_PER_UNIT = 2,
    parameter int IDLE_TIMEOUT = 10,
    parameter int DONE_HOLD    = 3
) (
    input  logic     clk,
    input  logic     rst_n,
    charger_if.slave bus
);
    localparam int HOLD_W = (DONE_HOLD > 2) ? $clog2(DONE_HOLD) : 1;

    // Parameter sets that would overflow the 5-bit balance or 6-bit time are rejected.
    if (TICK_DIV < 2 || MAX_MONEY < 1 || MAX_MONEY > 31 || MAX_MONEY * SEC_PER_UNIT > 63 ||
        IDLE_TIMEOUT < 1 || DONE_HOLD < 1) begin : g_bad_params
        $error("charger_controller: unsupported parameter combination");
    end

    state_e             state_q,  state_d;
    logic [MONEY_W-1:0] money_q,  money_d;
    logic [TIME_W-1:0]  remain_q, remain_d;
    logic [HOLD_W-1:0]  hold_q,   hold_d;

    logic               tick;
    logic               coin_any;
    logic               coin_ok;
    logic               state_chg;
    logic [MONEY_W-1:0] coin_val;

`ifdef CHARGER_TIMEOUT_EN
    localparam int IDLE_W = (IDLE_TIMEOUT > 2) ? $clog2(IDLE_TIMEOUT) : 1;
    logic [IDLE_W-1:0] idle_q, idle_d;
`endif

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state_chg | coin_ok),
        .tick  (tick)
    );

    assign coin_any = bus.coin_1 | bus.coin_10;
    assign coin_val = coin_value(bus.coin_1, bus.coin_10);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d  = state_q;
        money_d  = money_q;
        remain_d = remain_q;
        hold_d   = hold_q;
        coin_ok  = 1'b0;
`ifdef CHARGER_TIMEOUT_EN
        idle_d   = idle_q;
`endif
        if (bus.power_off) begin
            state_d  = S_OFF;
            money_d  = '0;
            remain_d = '0;
        end else begin
            case (state_q)
                S_OFF: begin
                    if (bus.power_on) state_d = S_STANDBY;
                end
                S_STANDBY: begin
                    if (coin_any) begin
                        state_d = S_INPUT;
                        money_d = sat_add('0, coin_val, MAX_MONEY);
                        coin_ok = 1'b1;
                    end
                end
                S_INPUT: begin
                    if (bus.cancel) begin
                        state_d = S_STANDBY;
                        money_d = '0;
                    end else if (bus.start && money_q != '0) begin
                        state_d  = S_CHARGE;
                        remain_d = TIME_W'(money_q) * TIME_W'(SEC_PER_UNIT);
                        money_d  = '0;
                    end else if (coin_any) begin
                        money_d = sat_add(money_q, coin_val, MAX_MONEY);
                        coin_ok = 1'b1;
`ifdef CHARGER_TIMEOUT_EN
                        idle_d  = '0;
                    end else if (tick) begin
                        if (idle_q == IDLE_W'(IDLE_TIMEOUT - 1)) begin
                            state_d = S_STANDBY;
                            money_d = '0;
                        end else begin
                            idle_d = idle_q + 1'b1;
                        end
`endif
                    end
                end
                S_CHARGE: begin
                    if (tick) begin
                        if (remain_q <= TIME_W'(1)) begin
                            remain_d = '0;
                            state_d  = S_DONE;
                        end else begin
                            remain_d = remain_q - 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (tick) begin
                        if (hold_q == HOLD_W'(DONE_HOLD - 1)) state_d = S_STANDBY;
                        else                                  hold_d  = hold_q + 1'b1;
                    end
                end
                default: state_d = S_OFF;
            endcase
        end

        // Per-state tick counters always start from zero in the state being entered.
        state_chg = (state_d != state_q);
        if (state_chg) begin
            hold_d = '0;
`ifdef CHARGER_TIMEOUT_EN
            idle_d = '0;
`endif
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_OFF;
            money_q  <= '0;
            remain_q <= '0;
            hold_q   <= '0;
        end else begin
            state_q  <= state_d;
            money_q  <= money_d;
            remain_q <= remain_d;
            hold_q   <= hold_d;
        end
    end

`ifdef CHARGER_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) idle_q <= '0;
        else        idle_q <= idle_d;
    end
`endif

    assign bus.state       = state_q;
    assign bus.money       = money_q;
    assign bus.remain_time = remain_q;

endmodule

// File: tb/tb_charger_controller.sv
// Self-checking bench for charger_controller: directed scenarios plus random pulses,
// checked cycle by cycle against a behavioural model through an expectation queue.
module tb_charger_controller;

    localparam int TICK_DIV     = 4;
    localparam int MAX_MONEY    = 20;
    localparam int SEC_PER_UNIT = 2;
    localparam int IDLE_TIMEOUT = 10;
    localparam int DONE_HOLD    = 3;

    localparam int M_OFF = 0, M_STANDBY = 1, M_INPUT = 2, M_CHARGE = 3, M_DONE = 4;

`ifdef CHARGER_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    charger_if bus();

    charger_controller #(
        .TICK_DIV     (TICK_DIV),
        .MAX_MONEY    (MAX_MONEY),
        .SEC_PER_UNIT (SEC_PER_UNIT),
        .IDLE_TIMEOUT (IDLE_TIMEOUT),
        .DONE_HOLD    (DONE_HOLD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int e_state;
        int e_money;
        int e_remain;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Behavioural model: absolute edge numbers, ticks every TICK_DIV edges after the last restart.
    int m_state, m_money, m_remain, m_idle, m_hold;
    int m_cyc = 0;
    int m_last_restart = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_state = M_OFF; m_money = 0; m_remain = 0; m_idle = 0; m_hold = 0;
        m_last_restart = m_cyc;
    endfunction

    function automatic void model_step(input bit pon, input bit poff, input bit c1,
                                       input bit c10, input bit st, input bit cn);
        int prev;
        int val;
        bit tick;
        bit coin_taken;
        m_cyc++;
        tick = (m_cyc > m_last_restart) && ((m_cyc - m_last_restart) % TICK_DIV == 0);
        val  = (c1 ? 1 : 0) + (c10 ? 10 : 0);
        prev = m_state;
        coin_taken = 1'b0;
        if (poff) begin
            m_state = M_OFF; m_money = 0; m_remain = 0;
        end else begin
            case (m_state)
                M_OFF:     if (pon) m_state = M_STANDBY;
                M_STANDBY: if (val > 0) begin
                    m_state = M_INPUT;
                    m_money = (val > MAX_MONEY) ? MAX_MONEY : val;
                    coin_taken = 1'b1;
                end
                M_INPUT: begin
                    if (cn) begin
                        m_state = M_STANDBY; m_money = 0;
                    end else if (st && m_money > 0) begin
                        m_remain = m_money * SEC_PER_UNIT; m_money = 0; m_state = M_CHARGE;
                    end else if (val > 0) begin
                        m_money = (m_money + val > MAX_MONEY) ? MAX_MONEY : m_money + val;
                        coin_taken = 1'b1;
                        m_idle = 0;
                    end else if (tick && TIMEOUT_EN) begin
                        m_idle++;
                        if (m_idle == IDLE_TIMEOUT) begin
                            m_state = M_STANDBY; m_money = 0;
                        end
                    end
                end
                M_CHARGE: if (tick) begin
                    m_remain--;
                    if (m_remain == 0) m_state = M_DONE;
                end
                M_DONE: if (tick) begin
                    m_hold++;
                    if (m_hold == DONE_HOLD) m_state = M_STANDBY;
                end
                default: m_state = M_OFF;
            endcase
        end
        if (m_state != prev) begin
            m_idle = 0;
            m_hold = 0;
        end
        if (m_state != prev || coin_taken) m_last_restart = m_cyc;
    endfunction

    task automatic drive(input bit pon, input bit poff, input bit c1, input bit c10,
                         input bit st, input bit cn);
        bus.power_on  = pon;
        bus.power_off = poff;
        bus.coin_1    = c1;
        bus.coin_10   = c10;
        bus.start     = st;
        bus.cancel    = cn;
    endtask

    // One clock of stimulus: inputs change at the falling edge, expectation queued for the next rise.
    task automatic step(input bit pon, input bit poff, input bit c1, input bit c10,
                        input bit st, input bit cn);
        @(negedge clk);
        drive(pon, poff, c1, c10, st, cn);
        model_step(pon, poff, c1, c10, st, cn);
        exp_q.push_back('{m_state, m_money, m_remain});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic look();
        @(posedge clk);
        #2;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        model_reset();
        model_step(0, 0, 0, 0, 0, 0);
        exp_q.push_back('{m_state, m_money, m_remain});
    endtask

    // Monitor: every rising edge with a pending expectation is compared just after the edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("mon_state",  32'(bus.state),       e.e_state);
            check("mon_money",  32'(bus.money),       e.e_money);
            check("mon_remain", 32'(bus.remain_time), e.e_remain);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached with %0d checks done", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r;
        drive(0, 0, 0, 0, 0, 0);
        model_reset();
        #3;
        check("reset_state",  32'(bus.state),       0);
        check("reset_money",  32'(bus.money),       0);
        check("reset_remain", 32'(bus.remain_time), 0);
        release_reset();

        // Bring-up and funding.
        step(1, 0, 0, 0, 0, 0); look(); check("bringup_standby", 32'(bus.state), 1);
        step(0, 0, 0, 1, 0, 0); look(); check("fund_input", 32'(bus.state), 2);
        check("fund_money10", 32'(bus.money), 10);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0); look(); check("fund_money12", 32'(bus.money), 12);
        step(0, 0, 0, 0, 1, 0); look(); check("start_state", 32'(bus.state), 3);
        check("start_remain24", 32'(bus.remain_time), 24);
        check("start_money0", 32'(bus.money), 0);

        // Asynchronous reset in the middle of a charge.
        for (int i = 0; i < 200 && m_remain != 7; i++) idle(1);
        @(posedge clk);
        #3;
        check("precharge_remain7", 32'(bus.remain_time), 7);
        rst_n = 1'b0;
        #1;
        check("async_rst_state",  32'(bus.state),       0);
        check("async_rst_money",  32'(bus.money),       0);
        check("async_rst_remain", 32'(bus.remain_time), 0);
        release_reset();

        // Saturation and cancel-over-start priority.
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0); look(); check("sat_first10", 32'(bus.money), 10);
        step(0, 0, 0, 1, 0, 0); look(); check("sat_second10", 32'(bus.money), 20);
        step(0, 0, 0, 1, 0, 0); look(); check("sat_third10", 32'(bus.money), 20);
        step(0, 0, 1, 1, 0, 0); look(); check("sat_both", 32'(bus.money), 20);
        step(0, 0, 0, 0, 1, 1); look(); check("cancel_start_state", 32'(bus.state), 1);
        check("cancel_start_money", 32'(bus.money), 0);

        // Start and cancel do nothing in STANDBY.
        step(0, 0, 0, 0, 1, 0); look(); check("standby_start", 32'(bus.state), 1);
        step(0, 0, 0, 0, 0, 1); look(); check("standby_cancel", 32'(bus.state), 1);

        // Countdown with a coin ignored during CHARGE.
        step(0, 0, 1, 0, 0, 0); look(); check("cd_money1", 32'(bus.money), 1);
        step(0, 0, 0, 0, 1, 0); look(); check("cd_remain2", 32'(bus.remain_time), 2);
        idle(1);
        step(0, 0, 0, 1, 0, 0); look(); check("charge_coin_money", 32'(bus.money), 0);
        idle(1); look(); check("cd_still2", 32'(bus.remain_time), 2);
        idle(1); look(); check("cd_remain1", 32'(bus.remain_time), 1);
        idle(3);
        idle(1); look(); check("cd_remain0", 32'(bus.remain_time), 0);
        check("cd_done", 32'(bus.state), 4);
        idle(11); look(); check("done_hold", 32'(bus.state), 4);
        idle(1); look(); check("done_to_standby", 32'(bus.state), 1);

        // power_off wins from DONE.
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        idle(8); look(); check("pwroff_in_done", 32'(bus.state), 4);
        step(0, 1, 0, 0, 0, 0); look(); check("pwroff_state", 32'(bus.state), 0);
        check("pwroff_remain", 32'(bus.remain_time), 0);
        step(0, 0, 1, 0, 0, 0); look(); check("off_ignores_coin", 32'(bus.money), 0);

        // Idle coin entry.
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
`ifdef CHARGER_TIMEOUT_EN
        idle(39); look(); check("timeout_not_yet", 32'(bus.state), 2);
        idle(1);  look(); check("timeout_state", 32'(bus.state), 1);
        check("timeout_money", 32'(bus.money), 0);
`else
        idle(1000); look(); check("no_timeout_state", 32'(bus.state), 2);
        check("no_timeout_money", 32'(bus.money), 1);
        step(0, 0, 0, 0, 0, 1);
`endif

        // Random pulses against the model.
        for (int i = 0; i < 2000; i++) begin
            r = $urandom_range(0, 99);
            if      (r < 60) step(0, 0, 0, 0, 0, 0);
            else if (r < 63) step(1, 0, 0, 0, 0, 0);
            else if (r < 64) step(0, 1, 0, 0, 0, 0);
            else if (r < 74) step(0, 0, 1, 0, 0, 0);
            else if (r < 80) step(0, 0, 0, 1, 0, 0);
            else if (r < 82) step(0, 0, 1, 1, 0, 0);
            else if (r < 90) step(0, 0, 0, 0, 1, 0);
            else if (r < 95) step(0, 0, 0, 0, 0, 1);
            else             step(0, 0, 0, 0, 1, 1);
        end

        look();
        check("queue_drained", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
